timer_bus_arbiter: RTL and testbench
====================================

// Module: timer_bus_arbiter
// PURPOSE
//  Shares the single register port of timer0 (CTRL/PRESET/COUNT) between two
//  bus masters: M0 = CPU data port, M1 = secondary master (debug/DMA).
//  Registers each granted access, drives the timer port for exactly one cycle,
//  and returns read data with a one-cycle ACK pulse. Round-robin on contention.
// PARAMETERS
//  DW        32  data width of master and timer data buses
//  M1_WR_EN  1   1: M1 may write; 0: M1 writes are dropped (WE_O stays 0), still ACKed
// PORTS
//  CLK_I      in   1   clock, all state on rising edge
//  RST_N_I    in   1   asynchronous, active-low reset
//  M0_REQ_I   in   1   M0 request; held high until M0_ACK_O seen
//  M0_ADD_I   in   2   M0 register select [3:2] (00 CTRL, 01 PRESET, 10 COUNT)
//  M0_WE_I    in   1   M0 write enable
//  M0_DAT_I   in   DW  M0 write data
//  M0_ACK_O   out  1   M0 completion pulse (1 cycle)
//  M0_DAT_O   out  DW  M0 read data, valid while M0_ACK_O=1
//  M1_REQ_I   in   1   M1 request (same rules as M0)
//  M1_ADD_I   in   2   M1 register select
//  M1_WE_I    in   1   M1 write enable
//  M1_DAT_I   in   DW  M1 write data
//  M1_ACK_O   out  1   M1 completion pulse
//  M1_DAT_O   out  DW  M1 read data, valid while M1_ACK_O=1
//  T_ADD_O    out  2   to timer ADD_I
//  T_WE_O     out  1   to timer WE_I
//  T_DAT_O    out  DW  to timer DAT_I
//  T_DAT_I    in   DW  from timer DAT_O (combinational read)
// BEHAVIOUR
//  Reset (RST_N_I=0, immediate): state=IDLE, M0/M1_ACK_O=0, T_WE_O=0,
//   T_ADD_O=0, T_DAT_O=0, read-data reg=0, last_grant=M1 (so M0 wins first tie).
//  FSM: IDLE -> ACCESS -> ACK -> IDLE; one access in flight max.
//  IDLE: if any REQ high, pick winner, latch its ADD/WE/DAT and id into
//   T_ADD_O/T_WE_O/T_DAT_O registers, go ACCESS. No REQ: stay, T_WE_O=0.
//  Arbitration: only one REQ -> that master. Both -> master != last_grant;
//   last_grant updated at grant edge.
//  ACCESS (1 cycle): T_WE_O=latched WE (forced 0 if winner=M1 and M1_WR_EN=0);
//   T_DAT_I sampled at end of cycle into read-data reg; go ACK.
//  ACK (1 cycle): winner's ACK_O=1, its DAT_O=read-data reg; go IDLE.
//   Read data on a write access = timer value of that address pre-write.
//  Latency: REQ high at cycle n (IDLE) -> timer access cycle n+1 -> ACK n+2.
//   Back-to-back: next grant sampled at n+3; min spacing 3 cycles.
//  Outside ACCESS T_WE_O=0; T_ADD_O/T_DAT_O hold last latched value.
//  Mx_DAT_O holds last read-data reg value when not ACKed (not guaranteed).
//  Loser's REQ stays pending; served next IDLE cycle it is still high.
//  REQ dropped before ACK: not supported; access already latched completes.
//  Granted master's REQ ignored in ACCESS/ACK; new REQ only sampled in IDLE.
//  ADD=11: forwarded as-is; timer returns 0, write ignored by timer.
//  Reset mid-access: access aborted, no ACK, T_WE_O low at once; a write
//   already presented on a previous edge has reached the timer, others not.
// TESTING
//  M0 write ADD=01 DAT=0x64 alone -> T_WE_O=1,T_ADD_O=01,T_DAT_O=0x64 at n+1; M0_ACK_O at n+2 only.
//  M1 read ADD=10 with COUNT=0x2A -> M1_ACK_O at n+2, M1_DAT_O=0x2A; T_WE_O stays 0.
//  Both REQ at once after reset, held -> M0 granted first, M1 ACK 3 cycles after M0 ACK.
//  Both REQ continuously for 8 accesses -> ACKs alternate M0,M1,M0,...; no master starved.
//  M1_WR_EN=0, M1 write CTRL=0x9 -> M1_ACK_O pulses, T_WE_O never 1, timer CTRL unchanged.
//  RST_N_I low during ACCESS of M0 write -> T_WE_O drops async, no ACK, next grant goes to M0.

Source files
------------

// File: rtl/timer_bus_arbiter.sv
// timer_bus_arbiter: shares the timer0 register port between two bus masters.
// Each granted access is latched, presented to the timer for one cycle, and
// answered with a one-cycle ACK that carries the timer read data. Round-robin
// arbitration applies when both masters request in the same IDLE cycle.
module timer_bus_arbiter #(
  parameter int unsigned DW       = 32,
  parameter bit          M1_WR_EN = 1'b1
) (
  input  logic          CLK_I,
  input  logic          RST_N_I,
  input  logic          M0_REQ_I,
  input  logic [1:0]    M0_ADD_I,
  input  logic          M0_WE_I,
  input  logic [DW-1:0] M0_DAT_I,
  output logic          M0_ACK_O,
  output logic [DW-1:0] M0_DAT_O,
  input  logic          M1_REQ_I,
  input  logic [1:0]    M1_ADD_I,
  input  logic          M1_WE_I,
  input  logic [DW-1:0] M1_DAT_I,
  output logic          M1_ACK_O,
  output logic [DW-1:0] M1_DAT_O,
  output logic [1:0]    T_ADD_O,
  output logic          T_WE_O,
  output logic [DW-1:0] T_DAT_O,
  input  logic [DW-1:0] T_DAT_I
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  // r_last / r_win: 0 = M0, 1 = M1
  logic          r_last;
  logic          w_last_nxt;
  logic          r_win;
  logic          w_win_nxt;
  logic [1:0]    r_t_add;
  logic [1:0]    w_t_add_nxt;
  logic          r_t_we;
  logic          w_t_we_nxt;
  logic [DW-1:0] r_t_dat;
  logic [DW-1:0] w_t_dat_nxt;
  logic [DW-1:0] r_rdata;
  logic [DW-1:0] w_rdata_nxt;
  logic          r_ack0;
  logic          w_ack0_nxt;
  logic          r_ack1;
  logic          w_ack1_nxt;

  logic          w_req_any;
  logic          w_pick;
  logic          w_pick_we;

  assign w_req_any = M0_REQ_I | M1_REQ_I;
  // Lone requester wins; on a tie the master that was not granted last wins.
  assign w_pick    = (M0_REQ_I & M1_REQ_I) ? ~r_last : M1_REQ_I;
  // M1 writes are squashed when M1 has no write permission; the access is still ACKed.
  assign w_pick_we = w_pick ? (M1_WE_I & M1_WR_EN) : M0_WE_I;

  // State register.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE -> ACCESS -> ACK -> IDLE, one access in flight.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_req_any) w_state_nxt = S_ACCESS;
      S_ACCESS: w_state_nxt = S_ACK;
      S_ACK:    w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output/datapath next values: latch winner in IDLE, capture read data in ACCESS.
  always_comb begin
    w_last_nxt  = r_last;
    w_win_nxt   = r_win;
    w_t_add_nxt = r_t_add;
    w_t_we_nxt  = 1'b0;
    w_t_dat_nxt = r_t_dat;
    w_rdata_nxt = r_rdata;
    w_ack0_nxt  = 1'b0;
    w_ack1_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req_any) begin
          w_win_nxt   = w_pick;
          w_last_nxt  = w_pick;
          w_t_add_nxt = w_pick ? M1_ADD_I : M0_ADD_I;
          w_t_dat_nxt = w_pick ? M1_DAT_I : M0_DAT_I;
          w_t_we_nxt  = w_pick_we;
        end
      end
      S_ACCESS: begin
        w_rdata_nxt = T_DAT_I;
        w_ack0_nxt  = ~r_win;
        w_ack1_nxt  = r_win;
      end
      default: begin
      end
    endcase
  end

  // Registered outputs and datapath; reset aborts any access in flight.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_last  <= 1'b1;
      r_win   <= 1'b0;
      r_t_add <= 2'd0;
      r_t_we  <= 1'b0;
      r_t_dat <= '0;
      r_rdata <= '0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
    end else begin
      r_last  <= w_last_nxt;
      r_win   <= w_win_nxt;
      r_t_add <= w_t_add_nxt;
      r_t_we  <= w_t_we_nxt;
      r_t_dat <= w_t_dat_nxt;
      r_rdata <= w_rdata_nxt;
      r_ack0  <= w_ack0_nxt;
      r_ack1  <= w_ack1_nxt;
    end
  end

  assign T_ADD_O  = r_t_add;
  assign T_WE_O   = r_t_we;
  assign T_DAT_O  = r_t_dat;
  assign M0_ACK_O = r_ack0;
  assign M1_ACK_O = r_ack1;
  assign M0_DAT_O = r_rdata;
  assign M1_DAT_O = r_rdata;

endmodule

// File: tb/tb_timer_bus_arbiter.sv
// Bench for timer_bus_arbiter: two instances (M1 write-enabled / write-disabled)
// share the master stimulus; each drives its own timer register model. A
// transaction-level reference predicts grants, timer strobes, ACKs and read data.
module tb_timer_bus_arbiter;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req;
  logic [1:0]    add [2];
  logic [1:0]    we;
  logic [DW-1:0] dat [2];

  logic          a_ack0, a_ack1, a_twe, b_ack0, b_ack1, b_twe;
  logic [DW-1:0] a_dat0, a_dat1, a_tdat, a_tin, b_dat0, b_dat1, b_tdat, b_tin;
  logic [1:0]    a_tadd, b_tadd;

  always #5 clk = ~clk;

  timer_bus_arbiter #(.DW(DW), .M1_WR_EN(1'b1)) u_dut_rw (
    .CLK_I(clk), .RST_N_I(rst_n),
    .M0_REQ_I(req[0]), .M0_ADD_I(add[0]), .M0_WE_I(we[0]), .M0_DAT_I(dat[0]),
    .M0_ACK_O(a_ack0), .M0_DAT_O(a_dat0),
    .M1_REQ_I(req[1]), .M1_ADD_I(add[1]), .M1_WE_I(we[1]), .M1_DAT_I(dat[1]),
    .M1_ACK_O(a_ack1), .M1_DAT_O(a_dat1),
    .T_ADD_O(a_tadd), .T_WE_O(a_twe), .T_DAT_O(a_tdat), .T_DAT_I(a_tin)
  );

  timer_bus_arbiter #(.DW(DW), .M1_WR_EN(1'b0)) u_dut_ro (
    .CLK_I(clk), .RST_N_I(rst_n),
    .M0_REQ_I(req[0]), .M0_ADD_I(add[0]), .M0_WE_I(we[0]), .M0_DAT_I(dat[0]),
    .M0_ACK_O(b_ack0), .M0_DAT_O(b_dat0),
    .M1_REQ_I(req[1]), .M1_ADD_I(add[1]), .M1_WE_I(we[1]), .M1_DAT_I(dat[1]),
    .M1_ACK_O(b_ack1), .M1_DAT_O(b_dat1),
    .T_ADD_O(b_tadd), .T_WE_O(b_twe), .T_DAT_O(b_tdat), .T_DAT_I(b_tin)
  );

  // Timer register files (index 3 is the unmapped address: reads 0, never written).
  logic [DW-1:0] tmr_a [4];
  logic [DW-1:0] tmr_b [4];
  logic          tmr_load;

  assign a_tin = tmr_a[a_tadd];
  assign b_tin = tmr_b[b_tadd];

  // Timer write port, with a load of the initial register contents.
  always @(posedge clk) begin
    if (tmr_load) begin
      tmr_a <= '{32'h0, 32'h0, 32'h2A, 32'h0};
      tmr_b <= '{32'h0, 32'h0, 32'h2A, 32'h0};
    end else begin
      if (a_twe && a_tadd != 2'd3) tmr_a[a_tadd] <= a_tdat;
      if (b_twe && b_tadd != 2'd3) tmr_b[b_tadd] <= b_tdat;
    end
  end

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected register contents and the access in flight.
  logic [DW-1:0] m_regs_a [4];
  logic [DW-1:0] m_regs_b [4];
  logic          m_pend, m_done, m_win, m_last, m_we;
  logic [1:0]    m_add;
  logic [DW-1:0] m_dat;
  logic          exp_we_a, exp_we_b;
  logic [1:0]    exp_ack;
  logic [1:0]    exp_tadd;
  logic [DW-1:0] exp_tdat, exp_rd_a, exp_rd_b;

  task automatic model_reset();
    m_pend = 1'b0; m_done = 1'b0; m_last = 1'b1; m_win = 1'b0;
    exp_we_a = 1'b0; exp_we_b = 1'b0; exp_ack = 2'b00;
    exp_tadd = 2'd0; exp_tdat = '0;
  endtask

  // Predicts what the coming clock edge does, from the inputs now applied.
  task automatic model_edge();
    if (!rst_n) return;
    exp_ack  = 2'b00;
    exp_we_a = 1'b0;
    exp_we_b = 1'b0;
    if (m_pend && !m_done) begin
      exp_rd_a = m_regs_a[m_add];
      exp_rd_b = m_regs_b[m_add];
      if (m_we && m_add != 2'd3) begin
        m_regs_a[m_add] = m_dat;
        if (!m_win) m_regs_b[m_add] = m_dat;
      end
      exp_ack[m_win] = 1'b1;
      m_done = 1'b1;
    end else if (m_pend) begin
      m_pend = 1'b0;
    end else if (req != 2'b00) begin
      m_win    = (req == 2'b11) ? !m_last : req[1];
      m_last   = m_win;
      m_add    = add[m_win];
      m_we     = we[m_win];
      m_dat    = dat[m_win];
      exp_tadd = m_add;
      exp_tdat = m_dat;
      exp_we_a = m_we;
      exp_we_b = m_we && !m_win;
      m_pend   = 1'b1;
      m_done   = 1'b0;
    end
  endtask

  task automatic issue(input int m, input logic [1:0] a, input logic w, input logic [DW-1:0] d);
    req[m] = 1'b1; add[m] = a; we[m] = w; dat[m] = d;
  endtask

  task automatic issue_rand(input int m);
    issue(m, 2'($urandom_range(3)), 1'($urandom_range(1)), $urandom);
  endtask

  // One clock: predict, clock, check both instances, retire ACKed requests.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("a_t_we",   {31'b0, a_twe},  {31'b0, exp_we_a});
    chk("b_t_we",   {31'b0, b_twe},  {31'b0, exp_we_b});
    chk("a_t_add",  {30'b0, a_tadd}, {30'b0, exp_tadd});
    chk("b_t_add",  {30'b0, b_tadd}, {30'b0, exp_tadd});
    chk("a_t_dat",  a_tdat, exp_tdat);
    chk("b_t_dat",  b_tdat, exp_tdat);
    chk("a_m0_ack", {31'b0, a_ack0}, {31'b0, exp_ack[0]});
    chk("a_m1_ack", {31'b0, a_ack1}, {31'b0, exp_ack[1]});
    chk("b_m0_ack", {31'b0, b_ack0}, {31'b0, exp_ack[0]});
    chk("b_m1_ack", {31'b0, b_ack1}, {31'b0, exp_ack[1]});
    if (exp_ack[0]) begin
      chk("a_m0_dat", a_dat0, exp_rd_a);
      chk("b_m0_dat", b_dat0, exp_rd_b);
    end
    if (exp_ack[1]) begin
      chk("a_m1_dat", a_dat1, exp_rd_a);
      chk("b_m1_dat", b_dat1, exp_rd_b);
    end
    for (int m = 0; m < 2; m++) if (exp_ack[m]) req[m] = 1'b0;
  endtask

  task automatic run_until_idle(input int unsigned max_cyc);
    int unsigned n = 0;
    while ((req != 2'b00 || m_pend) && n < max_cyc) begin
      step();
      n++;
    end
    if (req != 2'b00 || m_pend) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acks;
    int guard;
    logic prev_m;
    logic got_m;
    logic first;

    req = 2'b00; we = 2'b00;
    add[0] = 2'd0; add[1] = 2'd0; dat[0] = '0; dat[1] = '0;
    tmr_load = 1'b1;
    rst_n = 1'b0;
    m_regs_a = '{32'h0, 32'h0, 32'h2A, 32'h0};
    m_regs_b = '{32'h0, 32'h0, 32'h2A, 32'h0};
    exp_rd_a = '0; exp_rd_b = '0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_t_we",  {31'b0, a_twe},  32'd0);
    chk("rst_a_t_add", {30'b0, a_tadd}, 32'd0);
    chk("rst_a_t_dat", a_tdat, 32'd0);
    chk("rst_a_ack",   {30'b0, a_ack1, a_ack0}, 32'd0);
    chk("rst_b_ack",   {30'b0, b_ack1, b_ack0}, 32'd0);
    chk("rst_a_dat0",  a_dat0, 32'd0);
    tmr_load = 1'b0;
    #2 rst_n = 1'b1;

    // Lone M0 write to PRESET.
    issue(0, 2'd1, 1'b1, 32'h64);
    run_until_idle(20);
    // Lone M1 read of COUNT.
    issue(1, 2'd2, 1'b0, '0);
    run_until_idle(20);
    // Simultaneous requests: M0 first, M1 three cycles later.
    issue(0, 2'd0, 1'b0, '0);
    issue(1, 2'd1, 1'b0, '0);
    run_until_idle(20);
    // M1 write to CTRL: lands only on the write-enabled instance.
    issue(1, 2'd0, 1'b1, 32'h9);
    run_until_idle(20);
    chk("ro_ctrl_kept", tmr_b[0], 32'h0);
    chk("rw_ctrl_set",  tmr_a[0], 32'h9);
    // Unmapped address access.
    issue(0, 2'd3, 1'b1, 32'hDEAD_BEEF);
    run_until_idle(20);

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      for (int m = 0; m < 2; m++)
        if (!req[m] && $urandom_range(99) < 35) issue_rand(m);
      step();
    end
    run_until_idle(20);

    // Both masters saturating: ACKs must alternate.
    issue_rand(0);
    issue_rand(1);
    acks = 0; guard = 0; first = 1'b1; prev_m = 1'b0;
    while (acks < 8 && guard < 100) begin
      step();
      guard++;
      if (a_ack0 || a_ack1) begin
        got_m = a_ack1;
        if (!first) chk("alternate", {31'b0, got_m}, {31'b0, !prev_m});
        prev_m = got_m;
        first  = 1'b0;
        acks++;
      end
      for (int m = 0; m < 2; m++) if (!req[m] && acks < 8) issue_rand(m);
    end
    if (acks < 8) chk("alternate_timeout", 32'(acks), 32'd8);
    run_until_idle(20);

    // Reset during the ACCESS cycle of an M0 write.
    issue(0, 2'd1, 1'b1, 32'h55);
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_a_t_we", {31'b0, a_twe}, 32'd0);
    chk("rst_mid_b_t_we", {31'b0, b_twe}, 32'd0);
    req = 2'b00;
    model_reset();
    step();
    #2 rst_n = 1'b1;
    issue(0, 2'd1, 1'b0, '0);
    issue(1, 2'd2, 1'b0, '0);
    step();
    chk("post_rst_grant_m0", {31'b0, m_win}, 32'd0);
    run_until_idle(20);

    for (int i = 0; i < 4; i++) begin
      chk("tmr_a_final", tmr_a[i], m_regs_a[i]);
      chk("tmr_b_final", tmr_b[i], m_regs_b[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
